// File: rtl/weather_feature_builder_if.sv
// Sample-in / feature-set-out bundle for weather_feature_builder.
// master = sample source and feature consumer, slave = the feature builder.
// With WFB_PRECIP_SAT_FLAG_EN defined the bundle also carries precip_sat.
interface weather_feature_builder_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_temp;
    logic [7:0] s_precip;
    logic [7:0] s_wind;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_temp_max;
    logic [3:0] out_temp_min;
    logic [3:0] out_precipitation;
    logic [3:0] out_wind;
    logic [7:0] sample_cnt;
`ifdef WFB_PRECIP_SAT_FLAG_EN
    logic       precip_sat;
`endif

    modport master (
        output s_valid, s_temp, s_precip, s_wind, out_ready,
        input  s_ready, out_valid, out_temp_max, out_temp_min,
               out_precipitation, out_wind, sample_cnt
`ifdef WFB_PRECIP_SAT_FLAG_EN
        , input precip_sat
`endif
    );

    modport slave (
        input  s_valid, s_temp, s_precip, s_wind, out_ready,
        output s_ready, out_valid, out_temp_max, out_temp_min,
               out_precipitation, out_wind, sample_cnt
`ifdef WFB_PRECIP_SAT_FLAG_EN
        , output precip_sat
`endif
    );
endinterface

// File: rtl/weather_feature_builder.sv
// weather_feature_builder: reduces one day of raw sensor samples to daily
// max/min temperature, total precipitation and peak wind, quantises each to a
// 4-bit code and offers the set on a valid/ready handshake.
// Optional feature macro: WFB_PRECIP_SAT_FLAG_EN adds the precip_sat flag.
module weather_feature_builder #(
    parameter int SAMPLES_PER_DAY = 24,
    parameter int TEMP_SHIFT      = 4,
    parameter int PREC_SHIFT      = 6,
    parameter int WIND_SHIFT      = 4
) (
    input logic                      CLOCK_50,
    input logic                      rst,
    weather_feature_builder_if.slave bus
);
    localparam logic [7:0] DAY_LEN = 8'(SAMPLES_PER_DAY);

    typedef enum logic [1:0] {IDLE, ACCUM, QUANT, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  acc_max_reg, acc_min_reg, acc_wind_reg;
    logic [11:0] acc_prec_reg;
    logic [7:0]  sample_cnt_reg;
    logic        out_valid_reg;
    logic [3:0]  temp_max_reg, temp_min_reg, precip_reg, wind_reg;
    logic        accept, handshake;
    logic [7:0]  cnt_plus;
    logic [12:0] prec_sum;
    logic        prec_over;
`ifdef WFB_PRECIP_SAT_FLAG_EN
    logic        sat_seen_reg;
    logic        precip_sat_reg;
`else
    // Saturation of the precipitation total is silent in this build.
`endif

    assign bus.s_ready = (state_reg == IDLE) || (state_reg == ACCUM);
    assign accept      = bus.s_valid & bus.s_ready;
    assign handshake   = out_valid_reg & bus.out_ready;
    assign cnt_plus    = sample_cnt_reg + 8'd1;
    assign prec_sum    = {1'b0, acc_prec_reg} + {5'd0, bus.s_precip};
    assign prec_over   = (acc_prec_reg >> PREC_SHIFT) > 12'd15;

    assign bus.out_valid         = out_valid_reg;
    assign bus.out_temp_max      = temp_max_reg;
    assign bus.out_temp_min      = temp_min_reg;
    assign bus.out_precipitation = precip_reg;
    assign bus.out_wind          = wind_reg;
    assign bus.sample_cnt        = sample_cnt_reg;
`ifdef WFB_PRECIP_SAT_FLAG_EN
    assign bus.precip_sat        = precip_sat_reg;
`endif

    // State register.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state: the day ends on the accept that reaches DAY_LEN samples.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACCUM;
            ACCUM:   if (accept && (cnt_plus == DAY_LEN)) state_next = QUANT;
            QUANT:   state_next = HOLD;
            HOLD:    if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accumulators, quantised codes and output handshake.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            acc_max_reg    <= 8'h00;
            acc_min_reg    <= 8'hFF;
            acc_prec_reg   <= 12'h000;
            acc_wind_reg   <= 8'h00;
            sample_cnt_reg <= 8'd0;
            out_valid_reg  <= 1'b0;
            temp_max_reg   <= 4'd0;
            temp_min_reg   <= 4'd0;
            precip_reg     <= 4'd0;
            wind_reg       <= 4'd0;
`ifdef WFB_PRECIP_SAT_FLAG_EN
            sat_seen_reg   <= 1'b0;
            precip_sat_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    acc_max_reg    <= bus.s_temp;
                    acc_min_reg    <= bus.s_temp;
                    acc_prec_reg   <= {4'd0, bus.s_precip};
                    acc_wind_reg   <= bus.s_wind;
                    sample_cnt_reg <= 8'd1;
`ifdef WFB_PRECIP_SAT_FLAG_EN
                    sat_seen_reg   <= 1'b0;
`endif
                end
                ACCUM: if (accept) begin
                    if (bus.s_temp > acc_max_reg)  acc_max_reg  <= bus.s_temp;
                    if (bus.s_temp < acc_min_reg)  acc_min_reg  <= bus.s_temp;
                    if (bus.s_wind > acc_wind_reg) acc_wind_reg <= bus.s_wind;
                    sample_cnt_reg <= cnt_plus;
                    if (prec_sum[12]) begin
                        acc_prec_reg <= 12'hFFF;
`ifdef WFB_PRECIP_SAT_FLAG_EN
                        sat_seen_reg <= 1'b1;
`endif
                    end else begin
                        acc_prec_reg <= prec_sum[11:0];
                    end
                end
                QUANT: begin
                    temp_max_reg <= 4'(acc_max_reg >> TEMP_SHIFT);
                    temp_min_reg <= 4'(acc_min_reg >> TEMP_SHIFT);
                    wind_reg     <= 4'(acc_wind_reg >> WIND_SHIFT);
                    precip_reg   <= prec_over ? 4'hF : 4'(acc_prec_reg >> PREC_SHIFT);
`ifdef WFB_PRECIP_SAT_FLAG_EN
                    precip_sat_reg <= sat_seen_reg | prec_over;
`endif
                end
                HOLD: begin
                    // out_valid rises one cycle into HOLD, after the codes settle.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_reg  <= 1'b0;
                        acc_max_reg    <= 8'h00;
                        acc_min_reg    <= 8'hFF;
                        acc_prec_reg   <= 12'h000;
                        acc_wind_reg   <= 8'h00;
                        sample_cnt_reg <= 8'd0;
                    end
                end
                default: begin
                    out_valid_reg  <= 1'b0;
                    acc_max_reg    <= 8'h00;
                    acc_min_reg    <= 8'hFF;
                    acc_prec_reg   <= 12'h000;
                    acc_wind_reg   <= 8'h00;
                    sample_cnt_reg <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_weather_feature_builder.sv
// Directed testbench for weather_feature_builder: a 4-sample-per-day instance
// for most scenarios and a 24-sample-per-day instance for precip saturation.
module tb_weather_feature_builder;
    logic CLOCK_50 = 1'b0;
    logic rst = 1'b0;
    int compared = 0;
    int mismatched = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    weather_feature_builder_if bus_a ();
    weather_feature_builder_if bus_b ();

    weather_feature_builder #(.SAMPLES_PER_DAY(4)) dut_a (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus_a.slave)
    );

    weather_feature_builder #(.SAMPLES_PER_DAY(24)) dut_b (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus_b.slave)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_a(input logic [7:0] t, input logic [7:0] p, input logic [7:0] w);
        bus_a.s_valid = 1'b1; bus_a.s_temp = t; bus_a.s_precip = p; bus_a.s_wind = w;
        tick();
        bus_a.s_valid = 1'b0;
    endtask

    // Called right after the final accept: checks QUANT, first HOLD cycle, then codes.
    task automatic finish_day_a(input string tag, input logic [3:0] mx, input logic [3:0] mn,
                                input logic [3:0] pr, input logic [3:0] wd);
        check({tag, " s_ready quant"}, 16'(bus_a.s_ready), 16'd0);
        check({tag, " valid edge0"}, 16'(bus_a.out_valid), 16'd0);
        tick();
        check({tag, " valid edge1"}, 16'(bus_a.out_valid), 16'd0);
        tick();
        check({tag, " valid edge2"}, 16'(bus_a.out_valid), 16'd1);
        check({tag, " temp_max"}, 16'(bus_a.out_temp_max), 16'(mx));
        check({tag, " temp_min"}, 16'(bus_a.out_temp_min), 16'(mn));
        check({tag, " precip"}, 16'(bus_a.out_precipitation), 16'(pr));
        check({tag, " wind"}, 16'(bus_a.out_wind), 16'(wd));
    endtask

    task automatic handshake_a(input string tag, input logic [3:0] mx);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        check({tag, " valid after hs"}, 16'(bus_a.out_valid), 16'd0);
        check({tag, " cnt after hs"}, 16'(bus_a.sample_cnt), 16'd0);
        check({tag, " max held"}, 16'(bus_a.out_temp_max), 16'(mx));
        check({tag, " s_ready idle"}, 16'(bus_a.s_ready), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [7];
        int exp_cnt [7];
        pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_cnt = '{1, 1, 1, 2, 3, 3, 4};

        bus_a.s_valid = 1'b0; bus_a.s_temp = 8'd0; bus_a.s_precip = 8'd0; bus_a.s_wind = 8'd0;
        bus_a.out_ready = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_temp = 8'd0; bus_b.s_precip = 8'd0; bus_b.s_wind = 8'd0;
        bus_b.out_ready = 1'b0;

        // 1: reset asserted mid-cycle
        #12 rst = 1'b1;
        #1;
        check("rst valid", 16'(bus_a.out_valid), 16'd0);
        check("rst temp_max", 16'(bus_a.out_temp_max), 16'd0);
        check("rst temp_min", 16'(bus_a.out_temp_min), 16'd0);
        check("rst precip", 16'(bus_a.out_precipitation), 16'd0);
        check("rst wind", 16'(bus_a.out_wind), 16'd0);
        check("rst cnt", 16'(bus_a.sample_cnt), 16'd0);
        check("rst s_ready", 16'(bus_a.s_ready), 16'd1);
        #4 rst = 1'b0;
        tick();

        // 2: basic day
        send_a(8'd40, 8'd0, 8'd10);
        check("t2 cnt1", 16'(bus_a.sample_cnt), 16'd1);
        send_a(8'd200, 8'd0, 8'd50);
        send_a(8'd120, 8'd0, 8'd30);
        send_a(8'd80, 8'd0, 8'd20);
        check("t2 cnt4", 16'(bus_a.sample_cnt), 16'd4);
        finish_day_a("t2", 4'd12, 4'd2, 4'd0, 4'd3);
        handshake_a("t2", 4'd12);

        // 3: 24 samples of precip 255 saturate the total
        for (int i = 0; i < 24; i++) begin
            bus_b.s_valid = 1'b1; bus_b.s_temp = 8'd100; bus_b.s_precip = 8'd255; bus_b.s_wind = 8'd0;
            tick();
        end
        bus_b.s_valid = 1'b0;
        check("t3 cnt24", 16'(bus_b.sample_cnt), 16'd24);
        tick();
        check("t3 valid edge1", 16'(bus_b.out_valid), 16'd0);
        tick();
        check("t3 valid edge2", 16'(bus_b.out_valid), 16'd1);
        check("t3 precip", 16'(bus_b.out_precipitation), 16'd15);
        check("t3 temp_max", 16'(bus_b.out_temp_max), 16'd6);
`ifdef WFB_PRECIP_SAT_FLAG_EN
        check("t3 precip_sat", 16'(bus_b.precip_sat), 16'd1);
`endif
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;
        check("t3 valid after hs", 16'(bus_b.out_valid), 16'd0);

        // 4: backpressure in HOLD, then a fresh day
        send_a(8'd48, 8'd64, 8'd80);
        send_a(8'd64, 8'd64, 8'd80);
        send_a(8'd32, 8'd64, 8'd80);
        send_a(8'd16, 8'd64, 8'd80);
        finish_day_a("t4a", 4'd4, 4'd1, 4'd4, 4'd5);
        bus_a.s_valid = 1'b1; bus_a.s_temp = 8'd240; bus_a.s_precip = 8'd128; bus_a.s_wind = 8'd255;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4 stall s_ready", 16'(bus_a.s_ready), 16'd0);
            check("t4 stall cnt", 16'(bus_a.sample_cnt), 16'd4);
        end
        check("t4 stall valid", 16'(bus_a.out_valid), 16'd1);
        check("t4 stall temp_max", 16'(bus_a.out_temp_max), 16'd4);
        check("t4 stall precip", 16'(bus_a.out_precipitation), 16'd4);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        bus_a.s_valid = 1'b0;
        check("t4 hs valid", 16'(bus_a.out_valid), 16'd0);
        check("t4 hs cnt", 16'(bus_a.sample_cnt), 16'd0);
        send_a(8'd240, 8'd128, 8'd255);
        send_a(8'd0, 8'd128, 8'd0);
        send_a(8'd128, 8'd0, 8'd0);
        send_a(8'd64, 8'd0, 8'd0);
        finish_day_a("t4b", 4'd15, 4'd0, 4'd4, 4'd15);
        handshake_a("t4b", 4'd15);

        // 5: reset mid-day discards the partial day
        send_a(8'd255, 8'd255, 8'd255);
        send_a(8'd255, 8'd255, 8'd255);
        check("t5 cnt2", 16'(bus_a.sample_cnt), 16'd2);
        #2 rst = 1'b1;
        #1;
        check("t5 rst cnt", 16'(bus_a.sample_cnt), 16'd0);
        check("t5 rst max code", 16'(bus_a.out_temp_max), 16'd0);
        #1 rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send_a(8'd16, 8'd0, 8'd0);
        finish_day_a("t5", 4'd1, 4'd1, 4'd0, 4'd0);
        handshake_a("t5", 4'd1);

        // 6: s_valid gaps; only accepts advance sample_cnt
        bus_a.s_temp = 8'd80; bus_a.s_precip = 8'd64; bus_a.s_wind = 8'd16;
        for (int i = 0; i < 7; i++) begin
            bus_a.s_valid = pat[i];
            tick();
            check($sformatf("t6 cnt step%0d", i), 16'(bus_a.sample_cnt), 16'(exp_cnt[i]));
        end
        bus_a.s_valid = 1'b0;
        finish_day_a("t6", 4'd5, 4'd5, 4'd4, 4'd1);
        handshake_a("t6", 4'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
